// File: rtl/descrypt_dispatch_pkg.sv
// Shared constants and types for the descrypt input-side dispatcher.
//   DIN_MSB        : MSB of the broadcast data word (DIN_WIDTH = DIN_MSB + 1)
//   JOB_WORDS_DEF  : default number of words per crypt job
//   state_e        : dispatcher FSM encodings (IDLE, SEND, DONE)
package descrypt_dispatch_pkg;

    localparam int DIN_MSB       = 15;
    localparam int JOB_WORDS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/descrypt_dispatch_rr_select.sv
// Round-robin first-eligible finder (purely combinational).
//   elig_i  : per-core eligibility mask
//   ptr_i   : index where the search starts (wraps modulo N_CORES)
//   idx_o   : first eligible core at or after ptr_i
//   found_o : at least one core is eligible
module rr_select #(
    parameter int N_CORES = 4,
    parameter int IDX_W   = 2
) (
    input  logic [N_CORES-1:0] elig_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               found_o
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = '0;
        for (int k = 0; k < N_CORES; k++) begin
            pos = IDX_W'((int'(ptr_i) + k) % N_CORES);
            if (!found_o && elig_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

endmodule

// File: rtl/descrypt_dispatch.sv
// Input-side scheduler for the descrypt core array.
// Accepts job words from the host stream, picks a free core by round-robin
// and broadcasts each whole job on din/addr_in with a one-hot wr_en.
//   CORE_CLK, rst            : clock, asynchronous active-high reset
//   in_data/in_addr/in_valid : upstream job words; in_ready accepts them
//   din/addr_in/wr_en        : registered broadcast bus and write strobe
//   crypt_ready/core_idle/err_core : per-core status
//   all_idle/err_seq/err_any : aggregated status for the host
//   cur_core                 : index of the core currently being written
module descrypt_dispatch
    import descrypt_dispatch_pkg::*;
#(
    parameter int  N_CORES   = 4,
    parameter int  DIN_WIDTH = DIN_MSB + 1,
    parameter int  JOB_WORDS = JOB_WORDS_DEF,
    parameter int  HOLDOFF   = 4,
    localparam int IDX_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                 CORE_CLK,
    input  logic                 rst,
    input  logic [DIN_WIDTH-1:0] in_data,
    input  logic [2:0]           in_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DIN_WIDTH-1:0] din,
    output logic [2:0]           addr_in,
    output logic [N_CORES-1:0]   wr_en,
    input  logic [N_CORES-1:0]   crypt_ready,
    input  logic [N_CORES-1:0]   core_idle,
    input  logic [N_CORES-1:0]   err_core,
    output logic                 all_idle,
    output logic                 err_seq,
    output logic                 err_any,
    output logic [IDX_W-1:0]     cur_core
);

    localparam int         HOLD_W    = $clog2(HOLDOFF + 1);
    localparam logic [2:0] LAST_WORD = 3'(JOB_WORDS - 1);

    state_e             state_q;
    logic [2:0]         word_cnt_q;
    logic [IDX_W-1:0]   rr_q;
    logic [HOLD_W-1:0]  hold_q [N_CORES];

    logic [N_CORES-1:0] elig;
    logic [N_CORES-1:0] cur_onehot;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [IDX_W-1:0]   rr_d;

    // A core just written stays excluded until its holdoff counter drains,
    // covering the wrapper's input/ready register stages.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CORES; i++) begin
            elig[i] = crypt_ready[i] & ~err_core[i] & (hold_q[i] == '0);
        end
    end

    always_comb begin
        cur_onehot           = '0;
        cur_onehot[cur_core] = 1'b1;
    end

    assign rr_d = (int'(cur_core) == N_CORES - 1) ? '0 : cur_core + 1'b1;

    rr_select #(
        .N_CORES (N_CORES),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .elig_i  (elig),
        .ptr_i   (rr_q),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    always_ff @(posedge CORE_CLK or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            rr_q       <= '0;
            cur_core   <= '0;
            in_ready   <= 1'b0;
            din        <= '0;
            addr_in    <= '0;
            wr_en      <= '0;
            all_idle   <= 1'b0;
            err_seq    <= 1'b0;
            err_any    <= 1'b0;
            for (int i = 0; i < N_CORES; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            wr_en <= '0;

            for (int i = 0; i < N_CORES; i++) begin
                if (state_q == ST_DONE && int'(cur_core) == i) begin
                    hold_q[i] <= HOLD_W'(HOLDOFF);
                end else if (hold_q[i] != '0) begin
                    hold_q[i] <= hold_q[i] - 1'b1;
                end
            end

            // Reported idle only when the FSM will sit in IDLE next cycle.
            all_idle <= (&core_idle) &&
                        ((state_q == ST_IDLE && !sel_found) || state_q == ST_DONE);
            err_any  <= (|err_core) || err_seq;

            case (state_q)
                ST_IDLE: begin
                    if (sel_found) begin
                        cur_core   <= sel_idx;
                        word_cnt_q <= '0;
                        in_ready   <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Once granted, the job is locked to cur_core regardless
                    // of that core's ready/error flags.
                    if (in_valid) begin
                        din        <= in_data;
                        addr_in    <= in_addr;
                        wr_en      <= cur_onehot;
                        word_cnt_q <= word_cnt_q + 1'b1;
                        if (in_addr != word_cnt_q) begin
                            err_seq <= 1'b1;
                        end
                        if (word_cnt_q == LAST_WORD) begin
                            in_ready <= 1'b0;
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    rr_q    <= rr_d;
                    state_q <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_descrypt_dispatch.sv
// Self-checking bench for descrypt_dispatch (N_CORES=4, JOB_WORDS=8, HOLDOFF=4).
module tb_descrypt_dispatch;

    localparam int HOLDOFF = 4;

    logic        CORE_CLK;
    logic        rst;
    logic [15:0] in_data;
    logic [2:0]  in_addr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din;
    logic [2:0]  addr_in;
    logic [3:0]  wr_en;
    logic [3:0]  crypt_ready;
    logic [3:0]  core_idle;
    logic [3:0]  err_core;
    logic        all_idle;
    logic        err_seq;
    logic        err_any;
    logic [1:0]  cur_core;

    descrypt_dispatch #(
        .N_CORES   (4),
        .DIN_WIDTH (16),
        .JOB_WORDS (8),
        .HOLDOFF   (HOLDOFF)
    ) dut (
        .CORE_CLK    (CORE_CLK),
        .rst         (rst),
        .in_data     (in_data),
        .in_addr     (in_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din         (din),
        .addr_in     (addr_in),
        .wr_en       (wr_en),
        .crypt_ready (crypt_ready),
        .core_idle   (core_idle),
        .err_core    (err_core),
        .all_idle    (all_idle),
        .err_seq     (err_seq),
        .err_any     (err_any),
        .cur_core    (cur_core)
    );

    initial CORE_CLK = 1'b0;
    always #5 CORE_CLK = ~CORE_CLK;

    typedef struct {
        int         core;
        logic [2:0] a;
        logic [15:0] d;
        int         cyc;
        logic       first;
    } exp_t;

    typedef struct {
        logic       rst_before;
        logic [3:0] ready;
        logic [3:0] errc;
        int         core;
        logic       gap;
        logic       bad;
        logic       exp_seq;
        logic       exp_any;
    } job_t;

    exp_t sb[$];
    job_t jobs[14];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   job_pulses = 0;
    int   last_pulse[4];

    always @(posedge CORE_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every wr_en pulse must match the oldest accepted word.
    always @(negedge CORE_CLK) begin : mon
        exp_t e;
        if (!rst && wr_en != 4'b0) begin
            chk("sb_nonempty_on_wr_en", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_en_onehot", 32'($onehot(wr_en)), 32'd1);
                chk("wr_en", 32'(wr_en), 32'(1 << e.core));
                chk("din", 32'(din), 32'(e.d));
                chk("addr_in", 32'(addr_in), 32'(e.a));
                chk("latency", 32'(cyc), 32'(e.cyc + 1));
                chk("cur_core", 32'(cur_core), 32'(e.core));
                if (e.first && last_pulse[e.core] >= 0) begin
                    chk("holdoff_gap", 32'((cyc - last_pulse[e.core]) >= HOLDOFF + 2), 32'd1);
                end
                last_pulse[e.core] = cyc;
                job_pulses++;
            end
        end
    end

    task automatic clear_history();
        sb.delete();
        for (int i = 0; i < 4; i++) last_pulse[i] = -1;
    endtask

    task automatic reset_dut();
        @(negedge CORE_CLK);
        rst = 1'b1;
        in_valid = 1'b0;
        crypt_ready = 4'b0;
        err_core = 4'b0;
        repeat (2) @(negedge CORE_CLK);
        clear_history();
        rst = 1'b0;
        @(posedge CORE_CLK);
        #1;
    endtask

    task automatic put_word(input logic [15:0] d, input logic [2:0] a, input int core, input logic first);
        int   n;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_addr  = a;
        n = 0;
        @(negedge CORE_CLK);
        while (!in_ready && n < 60) begin
            @(negedge CORE_CLK);
            n++;
        end
        chk("in_ready_within_budget", 32'(in_ready), 32'd1);
        if (in_ready) begin
            e = '{core, a, d, cyc, first};
            sb.push_back(e);
            @(posedge CORE_CLK);
            #1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic run_job(input int core, input logic [15:0] base, input logic gap, input logic bad);
        job_pulses = 0;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] a;
            a = (bad && k >= 2) ? 3'(k + 1) : 3'(k);
            put_word(base + 16'(k), a, core, k == 0);
            if (gap && k == 3) begin
                in_valid = 1'b0;
                repeat (3) begin
                    @(posedge CORE_CLK);
                    #1;
                    chk("gap_wr_en", 32'(wr_en), 32'd0);
                end
                chk("gap_all_idle", 32'(all_idle), 32'd0);
            end
            if (bad && k == 1) chk("err_seq_before", 32'(err_seq), 32'd0);
            if (bad && k == 2) begin
                chk("err_seq_set", 32'(err_seq), 32'd1);
                chk("err_any_lag", 32'(err_any), 32'd0);
            end
            if (bad && k == 3) chk("err_any_set", 32'(err_any), 32'd1);
        end
        in_valid = 1'b0;
        @(negedge CORE_CLK);
        #1;
        chk("job_pulses", 32'(job_pulses), 32'd8);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_addr = '0;
        crypt_ready = 4'b0;
        core_idle = 4'b1111;
        err_core = 4'b0;
        clear_history();

        repeat (3) @(negedge CORE_CLK);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_addr_in", 32'(addr_in), 32'd0);
        chk("rst_all_idle", 32'(all_idle), 32'd0);
        chk("rst_err_seq", 32'(err_seq), 32'd0);
        chk("rst_err_any", 32'(err_any), 32'd0);
        chk("rst_cur_core", 32'(cur_core), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge CORE_CLK);
        #1;
        chk("idle_all_idle", 32'(all_idle), 32'd1);
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        //          rst   ready    errc     core gap   bad   seq   any
        jobs[0]  = '{1'b1, 4'b1111, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        jobs[1]  = '{1'b0, 4'b1111, 4'b0000, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        jobs[2]  = '{1'b1, 4'b0101, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        jobs[3]  = '{1'b0, 4'b0101, 4'b0000, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        jobs[4]  = '{1'b0, 4'b0101, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        jobs[5]  = '{1'b0, 4'b0101, 4'b0000, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        jobs[6]  = '{1'b0, 4'b1111, 4'b0000, 3, 1'b1, 1'b0, 1'b0, 1'b0};
        jobs[7]  = '{1'b0, 4'b1111, 4'b0000, 0, 1'b0, 1'b1, 1'b1, 1'b1};
        jobs[8]  = '{1'b1, 4'b1111, 4'b0010, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        jobs[9]  = '{1'b0, 4'b1111, 4'b0010, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        jobs[10] = '{1'b0, 4'b1111, 4'b0010, 3, 1'b0, 1'b0, 1'b0, 1'b1};
        jobs[11] = '{1'b0, 4'b1111, 4'b0010, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        jobs[12] = '{1'b1, 4'b0001, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        jobs[13] = '{1'b0, 4'b0001, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int j = 0; j < 14; j++) begin
            if (jobs[j].rst_before) reset_dut();
            crypt_ready = jobs[j].ready;
            err_core    = jobs[j].errc;
            run_job(jobs[j].core, 16'h0100 * 16'(j + 1), jobs[j].gap, jobs[j].bad);
            chk("job_err_seq", 32'(err_seq), 32'(jobs[j].exp_seq));
            chk("job_err_any", 32'(err_any), 32'(jobs[j].exp_any));
        end

        // Reset in the middle of a job: outputs clear immediately, next job restarts on core 0.
        reset_dut();
        crypt_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            put_word(16'h0A00 + 16'(k), 3'(k), 0, k == 0);
        end
        rst = 1'b1;
        #1;
        chk("async_rst_wr_en", 32'(wr_en), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        chk("async_rst_din", 32'(din), 32'd0);
        in_valid = 1'b0;
        @(negedge CORE_CLK);
        clear_history();
        @(negedge CORE_CLK);
        rst = 1'b0;
        @(posedge CORE_CLK);
        #1;
        run_job(0, 16'h0B00, 1'b0, 1'b0);
        chk("post_rst_err_seq", 32'(err_seq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
